// File: rtl/sram_port_ctrl.sv
// Byte/halfword request front end for the single-port SPRAM with a 3-entry read response FIFO.
// The SRam port is driven combinationally from the request; read data is captured one cycle after accept.
module sram_port_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic [14:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic [13:0] mem_addr,
  output logic        mem_write_enable,
  output logic [3:0]  mem_write_mask,
  output logic [15:0] mem_data_inp,
  input  logic [15:0] mem_data_out
);

  // Handshake: a transfer happens on a rising clock edge where valid & ready are both high;
  // ready never looks at valid, and valid-side payload is only meaningful while valid is high.

  logic [1:0]  fifo_count;
  logic        rd_pending;
  logic [1:0]  lane_tag;
  logic [15:0] fifo_mem [3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  occ;
  logic        acc;
  logic        push;
  logic        pop;
  logic [15:0] cap_data;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read in flight reserves its FIFO slot, so accepts stop before the FIFO could overflow.
  assign occ       = {1'b0, fifo_count} + {2'b00, rd_pending};
  assign req_ready = reset_n & (occ < 3'd3);
  assign acc       = req_valid & req_ready;
  assign push      = rd_pending;
  assign pop       = rsp_valid & rsp_ready;

  assign mem_addr         = req_addr[14:1];
  assign mem_write_enable = acc & req_write;

  always_comb begin
    mem_write_mask = 4'b1111;
    mem_data_inp   = req_wdata;
    if (!req_size) begin
      mem_write_mask = req_addr[0] ? 4'b1100 : 4'b0011;
      mem_data_inp   = {req_wdata[7:0], req_wdata[7:0]};
    end
  end

  always_comb begin
    cap_data = mem_data_out;
    if (!lane_tag[1]) begin
      cap_data = lane_tag[0] ? {8'h00, mem_data_out[15:8]} : {8'h00, mem_data_out[7:0]};
    end
  end

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      lane_tag   <= 2'b00;
      fifo_count <= 2'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_mem[i] <= 16'h0000;
    end else begin
      rd_pending <= acc & ~req_write;
      if (acc & ~req_write) lane_tag <= {req_size, req_addr[0]};
      if (push) begin
        fifo_mem[wr_ptr] <= cap_data;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: SPRAM model, byte-addressed reference memory and response queue model.
module tb_sram_port_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write, req_size;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic [13:0] mem_addr;
  logic        mem_write_enable;
  logic [3:0]  mem_write_mask;
  logic [15:0] mem_data_inp;
  logic [15:0] mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int acc_cnt = 0;

  logic [15:0] sram  [0:16383];
  logic [7:0]  ref_b [0:32767];
  logic [15:0] exp_q [$];
  logic        pend = 1'b0;
  logic [15:0] pend_val = 16'h0000;
  logic [15:0] rsp_log [$];
  int          pop_cyc [$];
  logic [15:0] nw;

  always #5 clock = ~clock;

  sram_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_mask(mem_write_mask), .mem_data_inp(mem_data_inp),
    .mem_data_out(mem_data_out)
  );

  // SPRAM: registered read of the old contents, nibble-masked write.
  always @(posedge clock) begin
    mem_data_out <= sram[mem_addr];
    if (mem_write_enable) begin
      nw = sram[mem_addr];
      for (int k = 0; k < 4; k++) if (mem_write_mask[k]) nw[4*k +: 4] = mem_data_inp[4*k +: 4];
      sram[mem_addr] = nw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic model_ready();
    return reset_n && ((exp_q.size() + int'(pend)) < 3);
  endfunction

  function automatic logic [15:0] rd_model(input logic s, input logic [14:0] a);
    logic [14:0] b;
    b = {a[14:1], 1'b0};
    if (s) return {ref_b[b | 15'd1], ref_b[b]};
    return {8'h00, ref_b[a]};
  endfunction

  task automatic wr_model(input logic s, input logic [14:0] a, input logic [15:0] d);
    logic [14:0] b;
    b = {a[14:1], 1'b0};
    if (s) begin
      ref_b[b]         = d[7:0];
      ref_b[b | 15'd1] = d[15:8];
    end else begin
      ref_b[a] = d[7:0];
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic cyc(input logic v, input logic w, input logic s, input logic [14:0] a,
                     input logic [15:0] d, input logic rr);
    logic rdy, acc;
    req_valid = v; req_write = w; req_size = s; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    rdy = model_ready();
    acc = v && rdy;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0]));
    chk("mem_addr", 32'(mem_addr), 32'(a[14:1]));
    chk("mem_we", 32'(mem_write_enable), 32'(acc && w));
    if (acc && w) begin
      chk("mem_mask", 32'(mem_write_mask), 32'(s ? 4'b1111 : (a[0] ? 4'b1100 : 4'b0011)));
      chk("mem_data_inp", 32'(mem_data_inp), 32'(s ? d : {d[7:0], d[7:0]}));
    end
    if (rsp_valid && rr) begin
      rsp_log.push_back(rsp_rdata);
      pop_cyc.push_back(cyc_n);
    end
    if (acc) acc_cnt++;
    @(posedge clock);
    if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
    if (pend) exp_q.push_back(pend_val);
    pend = acc && !w;
    if (acc && !w) pend_val = rd_model(s, a);
    if (acc && w) wr_model(s, a, d);
    cyc_n++;
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 20) begin
      cyc(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1);
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + int'(pend)), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w16;
    for (int i = 0; i < 16384; i++) begin
      w16 = 16'($urandom);
      sram[i] = w16;
      ref_b[2*i]     = w16[7:0];
      ref_b[2*i + 1] = w16[15:8];
    end
    reset_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1;
    req_addr = 15'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Byte write to the upper lane.
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b0; req_addr = 15'h0003; req_wdata = 16'h00A5;
    #1;
    chk("bw_addr", 32'(mem_addr), 32'h0001);
    chk("bw_mask", 32'(mem_write_mask), 32'b1100);
    chk("bw_data", 32'(mem_data_inp), 32'hA5A5);
    chk("bw_we", 32'(mem_write_enable), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 15'h0003, 16'h00A5, 1'b1);
    req_valid = 1'b0;
    #1;
    chk("bw_we_once", 32'(mem_write_enable), 32'd0);
    chk("bw_no_rsp", 32'(rsp_valid), 32'd0);

    // Halfword write then halfword and byte reads of the same word.
    rsp_log.delete();
    cyc(1'b1, 1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 15'h0010, 16'h0, 1'b0);
    #1 chk("lat_n1", 32'(rsp_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    #1 chk("lat_n2", 32'(rsp_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 15'h0011, 16'h0, 1'b0);
    drain();
    chk("hw_log_n", 32'(rsp_log.size()), 32'd3);
    if (rsp_log.size() == 3) begin
      chk("hw_rsp0", 32'(rsp_log[0]), 32'h1234);
      chk("hw_rsp1", 32'(rsp_log[1]), 32'h0034);
      chk("hw_rsp2", 32'(rsp_log[2]), 32'h0012);
    end

    // Back-to-back halfword reads with the response side always ready.
    rsp_log.delete(); pop_cyc.delete(); acc_cnt = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 15'(2*i), 16'h0, 1'b1);
    drain();
    chk("b2b_accepts", 32'(acc_cnt), 32'd8);
    chk("b2b_log_n", 32'(rsp_log.size()), 32'd8);
    if (pop_cyc.size() == 8) chk("b2b_no_gap", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // Backpressure: only three reads fit.
    rsp_log.delete(); acc_cnt = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 15'(16'h40 + 2*i), 16'h0, 1'b0);
    chk("bp_accepts", 32'(acc_cnt), 32'd3);
    #1 chk("bp_ready_low", 32'(req_ready), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1);
    #1 chk("bp_ready_back", 32'(req_ready), 32'd1);
    drain();
    chk("bp_log_n", 32'(rsp_log.size()), 32'd3);

    // Write to the same word right after a read.
    rsp_log.delete();
    cyc(1'b1, 1'b1, 1'b1, 15'h0020, 16'hBEEF, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 15'h0020, 16'h0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 15'h0020, 16'h5555, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 15'h0020, 16'h0, 1'b1);
    drain();
    chk("war_log_n", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      chk("war_old", 32'(rsp_log[0]), 32'hBEEF);
      chk("war_new", 32'(rsp_log[1]), 32'h5555);
    end

    // Randomized traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
          15'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with two reads outstanding.
    cyc(1'b1, 1'b0, 1'b1, 15'h0010, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 15'h0012, 16'h0, 1'b0);
    req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    exp_q.delete();
    pend = 1'b0;
    req_valid = 1'b1; req_write = 1'b1;
    #1 chk("mr_mem_we", 32'(mem_write_enable), 32'd0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("mr_ready_after", 32'(req_ready), 32'd1);
    chk("mr_no_stale", 32'(rsp_valid), 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 15'h0010, 16'h0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
